// File: rtl/warmboot_pkg.sv
// warmboot_sequencer shared types and constants.
// State encoding and flash timing at 48 MHz.
package warmboot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_QUIET = 3'd1,
    ST_DETACH     = 3'd2,
    ST_FLASH_WAKE = 3'd3,
    ST_SETTLE     = 3'd4,
    ST_BOOT       = 3'd5
  } wb_state_e;

  localparam int CLK_HZ   = 48_000_000;
  localparam int TRES1_NS = 3000;

  localparam logic [7:0] WAKE_CMD_DEF   = 8'hAB;
  localparam logic [1:0] BOOT_IMAGE_DEF = 2'b01;

  localparam int QUIET_CYCLES_DEF  = 48;
  localparam int DETACH_CYCLES_DEF = CLK_HZ / 100;
  localparam int SETTLE_CYCLES_DEF =
    (CLK_HZ / 1_000_000) * TRES1_NS / 1000;
  localparam int CNT_W_DEF         = 20;

endpackage

// File: rtl/warmboot_if.sv
// Bootloader/bridge side bundle of the warm-boot sequencer.
// master drives requests and bridge SPI, slave is the sequencer.
interface warmboot_if;

  logic       boot_req;
  logic       bridge_spi_cs;
  logic       bridge_spi_sck;
  logic       bridge_spi_mosi;
  logic       usb_tx_en_in;
  logic       spi_cs;
  logic       spi_sck;
  logic       spi_mosi;
  logic       usb_detach;
  logic       warmboot;
  logic [1:0] image_sel;
  logic       busy;

  modport master (
    output boot_req,
    output bridge_spi_cs,
    output bridge_spi_sck,
    output bridge_spi_mosi,
    output usb_tx_en_in,
    input  spi_cs,
    input  spi_sck,
    input  spi_mosi,
    input  usb_detach,
    input  warmboot,
    input  image_sel,
    input  busy
  );

  modport slave (
    input  boot_req,
    input  bridge_spi_cs,
    input  bridge_spi_sck,
    input  bridge_spi_mosi,
    input  usb_tx_en_in,
    output spi_cs,
    output spi_sck,
    output spi_mosi,
    output usb_detach,
    output warmboot,
    output image_sel,
    output busy
  );

endinterface

// File: rtl/spi_byte_tx.sv
// Single-byte SPI mode-0 transmitter, MSB first.
// 16 cycles with cs low: even phase sck=0, odd phase sck=1.
module spi_byte_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       cs,
  output logic       sck,
  output logic       mosi,
  output logic       done
);

  logic       active;
  logic [3:0] phase;
  logic [7:0] shreg;

  // phase walker; shift after each sck high phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      phase  <= 4'd0;
      shreg  <= 8'd0;
    end else if (start && !active) begin
      active <= 1'b1;
      phase  <= 4'd0;
      shreg  <= data;
    end else if (active) begin
      phase <= phase + 4'd1;
      if (phase[0]) begin
        shreg <= {shreg[6:0], 1'b0};
      end
      if (phase == 4'hF) begin
        active <= 1'b0;
      end
    end
  end

  assign cs   = ~active;
  assign sck  = active & phase[0];
  assign mosi = active & shreg[7];
  assign done = active && (phase == 4'hF);

endmodule

// File: rtl/warmboot_sequencer.sv
// Orderly handoff from boot request to warm-boot trigger:
// quiet wait, USB detach, flash wake, settle, boot.
module warmboot_sequencer
  import warmboot_pkg::*;
#(
  parameter int         QUIET_CYCLES  = QUIET_CYCLES_DEF,
  parameter int         DETACH_CYCLES = DETACH_CYCLES_DEF,
  parameter int         SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter logic [7:0] WAKE_CMD      = WAKE_CMD_DEF,
  parameter logic [1:0] BOOT_IMAGE    = BOOT_IMAGE_DEF,
  parameter int         CNT_W         = CNT_W_DEF
) (
  input logic       clk,
  input logic       reset,
  warmboot_if.slave bus
);

  localparam logic [CNT_W-1:0] QUIET_LAST  =
    CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] DETACH_LAST =
    CNT_W'(DETACH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  wb_state_e        state;
  wb_state_e        state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             quiet;
  logic             owned;
  logic             tx_start;
  logic             tx_cs;
  logic             tx_sck;
  logic             tx_mosi;
  logic             tx_done;

  assign quiet = bus.bridge_spi_cs & ~bus.usb_tx_en_in;
  assign owned = (state != ST_IDLE) &&
                 (state != ST_WAIT_QUIET);

  spi_byte_tx u_tx (
    .clk   (clk),
    .rst_n (reset),
    .start (tx_start),
    .data  (WAKE_CMD),
    .cs    (tx_cs),
    .sck   (tx_sck),
    .mosi  (tx_mosi),
    .done  (tx_done)
  );

  // state and shared delay counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // next state, counter and wake-byte launch
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tx_start = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (bus.boot_req) begin
          state_nx = ST_WAIT_QUIET;
        end
      end
      ST_WAIT_QUIET: begin
        if (!quiet) begin
          cnt_nx = '0;
        end else if (cnt == QUIET_LAST) begin
          state_nx = ST_DETACH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_DETACH: begin
        if (cnt == DETACH_LAST) begin
          state_nx = ST_FLASH_WAKE;
          cnt_nx   = '0;
          tx_start = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_FLASH_WAKE: begin
        if (tx_done) begin
          state_nx = ST_SETTLE;
          cnt_nx   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nx = ST_BOOT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_BOOT: begin
        cnt_nx = '0;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // pin ownership: bridge until quiet, then sequencer
  always_comb begin
    bus.spi_cs     = 1'b1;
    bus.spi_sck    = 1'b0;
    bus.spi_mosi   = 1'b0;
    bus.usb_detach = 1'b0;
    bus.warmboot   = 1'b0;
    bus.image_sel  = 2'b00;
    bus.busy       = reset && (state != ST_IDLE);
    if (!reset) begin
      bus.spi_cs = 1'b1;
    end else if (!owned) begin
      bus.spi_cs   = bus.bridge_spi_cs;
      bus.spi_sck  = bus.bridge_spi_sck;
      bus.spi_mosi = bus.bridge_spi_mosi;
    end else begin
      bus.spi_cs     = tx_cs;
      bus.spi_sck    = tx_sck;
      bus.spi_mosi   = tx_mosi;
      bus.usb_detach = 1'b1;
      if (state == ST_BOOT) begin
        bus.warmboot  = 1'b1;
        bus.image_sel = BOOT_IMAGE;
      end
    end
  end

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Bench for warmboot_sequencer: vector table, hand sequences
// and randomized runs against a timeline reference model.
module tb_warmboot_sequencer;

  localparam int QC  = 48;
  localparam int DC  = 100;
  localparam int SC  = 10;
  localparam int LEN = 600;

  typedef struct {
    string      nm;
    logic       rst;
    logic       boot;
    logic       cs;
    logic       sck;
    logic       mosi;
    logic       usb;
    logic [7:0] exp;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  warmboot_if bus();

  warmboot_sequencer #(
    .QUIET_CYCLES  (QC),
    .DETACH_CYCLES (DC),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic b, logic c, logic k,
                     logic m, logic u);
    bus.boot_req        = b;
    bus.bridge_spi_cs   = c;
    bus.bridge_spi_sck  = k;
    bus.bridge_spi_mosi = m;
    bus.usb_tx_en_in    = u;
  endtask

  // {cs, sck, mosi, detach, warmboot, image_sel, busy}
  function automatic logic [7:0] outs();
    return {bus.spi_cs, bus.spi_sck, bus.spi_mosi,
            bus.usb_detach, bus.warmboot,
            bus.image_sel, bus.busy};
  endfunction

  function automatic vec_t mk(string n, logic r, logic b,
                              logic c, logic k, logic m,
                              logic u, logic [7:0] e);
    vec_t v;
    v.nm = n; v.rst = r; v.boot = b; v.cs = c;
    v.sck = k; v.mosi = m; v.usb = u; v.exp = e;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    reset = 1'b1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  // reference: detach window = first window whose preceding
  // QC windows (all after the request) were quiet
  task automatic rand_trial(int t);
    bit         rq [LEN];
    bit         bc [LEN];
    bit         bk [LEN];
    bit         bm [LEN];
    bit         bu [LEN];
    int         r;
    int         d;
    int         k;
    int         f;
    bit         ok;
    logic [7:0] e;
    logic [7:0] cmd;
    cmd = 8'hAB;
    r = $urandom_range(60, 5);
    for (int w = 0; w < LEN; w++) begin
      rq[w] = (w < r) ? 1'b0 : (w == r) ? 1'b1 : rb();
      bk[w] = rb();
      bm[w] = rb();
      if (w >= 350) begin
        bc[w] = 1'b1;
        bu[w] = 1'b0;
      end else begin
        bc[w] = ($urandom_range(49, 0) != 0);
        bu[w] = ($urandom_range(59, 0) == 0);
      end
    end
    d = LEN;
    for (int e2 = r + QC + 1; e2 < LEN && d == LEN; e2++) begin
      ok = 1'b1;
      for (int j = e2 - QC; j < e2; j++) begin
        if (!bc[j] || bu[j]) ok = 1'b0;
      end
      if (ok) d = e2;
    end
    do_reset();
    for (int w = 0; w <= d + DC + 16 + SC + 4; w++) begin
      step();
      drv(rq[w], bc[w], bk[w], bm[w], bu[w]);
      #3;
      if (w < d) begin
        e = {bc[w], bk[w], bm[w], 1'b0, 1'b0, 2'b00,
             1'(w > r)};
      end else begin
        k = w - d;
        if (k < DC) begin
          e = 8'b1001_0001;
        end else if (k < DC + 16) begin
          f = k - DC;
          e = {1'b0, f[0], cmd[7 - f / 2], 1'b1, 1'b0,
               2'b00, 1'b1};
        end else if (k < DC + 16 + SC) begin
          e = 8'b1001_0001;
        end else begin
          e = 8'b1001_1011;
        end
      end
      chk($sformatf("rand%0d_w%0d", t, w), outs(), e);
    end
  endtask

  initial begin
    vec_t       tv [10];
    int         n;
    int         z;
    int         nerr;
    int         rises;
    logic       psck;
    logic [7:0] byte_v;
    logic       c;
    logic       k;
    logic       m;

    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    tv[0] = mk("rst_force_a", 0, 0, 0, 1, 1, 0, 8'h80);
    tv[1] = mk("rst_force_b", 0, 1, 1, 1, 1, 1, 8'h80);
    tv[2] = mk("pass_a",      1, 0, 0, 1, 1, 0, 8'h60);
    tv[3] = mk("pass_b",      1, 0, 1, 0, 1, 0, 8'hA0);
    tv[4] = mk("pass_c",      1, 0, 0, 0, 0, 1, 8'h00);
    tv[5] = mk("req_active",  1, 1, 0, 1, 0, 0, 8'h40);
    tv[6] = mk("sticky_wq",   1, 0, 1, 1, 1, 0, 8'hE1);
    tv[7] = mk("wq_usb",      1, 0, 0, 0, 1, 1, 8'h21);
    tv[8] = mk("rst_async",   0, 0, 0, 1, 1, 0, 8'h80);
    tv[9] = mk("rst_release", 1, 0, 0, 1, 1, 0, 8'h60);
    for (int i = 0; i < 10; i++) begin
      step();
      reset = tv[i].rst;
      drv(tv[i].boot, tv[i].cs, tv[i].sck,
          tv[i].mosi, tv[i].usb);
      #3;
      chk(tv[i].nm, outs(), tv[i].exp);
    end

    do_reset();
    for (int i = 0; i < 200; i++) begin
      step();
      c = rb(); k = rb(); m = rb();
      drv(1'b0, c, k, m, rb());
      #3;
      chk($sformatf("idle_pass_%0d", i), outs(),
          {c, k, m, 5'b00000});
    end

    // one-cycle request, bridge cs pulsed every 30 cycles
    do_reset();
    step();
    drv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    z = 0;
    nerr = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      drv(1'b0, 1'(i % 30 != 0), rb(), rb(), 1'b0);
      #3;
      if (bus.usb_detach || !bus.busy) nerr++;
      if (i % 30 == 0) z = 0;
      else z++;
    end
    chk("quiet_hold", nerr, 0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!bus.usb_detach && n < 500) begin
      step();
      #3;
      if (!bus.usb_detach) z++;
      n++;
    end
    chk("quiet_to_detach", z, QC);
    n = 0;
    while (bus.spi_cs && bus.usb_detach && n < 1000) begin
      n++;
      step();
      #3;
    end
    chk("detach_len", n, DC);
    n = 0;
    rises = 0;
    psck = 1'b0;
    byte_v = 8'h00;
    while (!bus.spi_cs && n < 100) begin
      n++;
      if (bus.spi_sck && !psck) begin
        rises++;
        byte_v = {byte_v[6:0], bus.spi_mosi};
      end
      psck = bus.spi_sck;
      step();
      #3;
    end
    chk("cs_low_len", n, 16);
    chk("sck_rises", rises, 8);
    chk("wake_byte", byte_v, 8'hAB);
    n = 0;
    while (!bus.warmboot && n < 1000) begin
      n++;
      step();
      #3;
    end
    chk("settle_len", n, SC);
    nerr = 0;
    for (int i = 0; i < 1000; i++) begin
      if (outs() !== 8'b1001_1011) nerr++;
      step();
      #3;
    end
    chk("boot_hold", nerr, 0);

    // reset after the 5th sck rise of the wake byte
    do_reset();
    step();
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    n = 0;
    while (bus.spi_cs && n < 400) begin
      n++;
      step();
      #3;
    end
    rises = 0;
    psck = bus.spi_sck;
    n = 0;
    while (rises < 5 && n < 40) begin
      step();
      #3;
      n++;
      if (bus.spi_sck && !psck) rises++;
      psck = bus.spi_sck;
    end
    chk("mid_rises", rises, 5);
    drv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_mid_byte", outs(), 8'h80);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rst_pass", outs(), 8'h60);
    step();
    drv(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #3;
    chk("rst_idle", outs(), 8'hA0);

    // USB transmit holds off the takeover
    do_reset();
    step();
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    nerr = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      #3;
      if (bus.usb_detach || !bus.busy) nerr++;
    end
    chk("usb_hold", nerr, 0);
    step();
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    n = 0;
    while (!bus.usb_detach && n < 200) begin
      n++;
      step();
      #3;
    end
    chk("usb_release", n, QC);

    for (int t = 0; t < 3; t++) begin
      rand_trial(t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/warmboot_sequencer.md
Name: warmboot_sequencer

Overview:
- Sits directly downstream of the bootloader's `boot` output.
- Takes the boot request (host-presence timeout OR bridge-issued boot) and sequences an orderly handoff:
  1. waits for SPI and USB to go quiet;
  2. detaches from USB so the host sees a disconnect;
  3. wakes the SPI flash with command 0xAB;
  4. holds the warm-boot primitive request.
- Owns the SPI pins only after quiet is reached; before that it passes the bridge SPI signals straight through.

Parameters:
- QUIET_CYCLES, 48: consecutive idle cycles (SPI cs high, USB tx off) required before taking over.
- DETACH_CYCLES, 480000: cycles usb_detach is held (10 ms at 48 MHz).
- SETTLE_CYCLES, 144: cycles cs is held high after the wake command (3 us tRES1).
- WAKE_CMD, 8'hAB: flash release-from-power-down opcode.
- BOOT_IMAGE, 2'b01: warm-boot image select value.
- CNT_W, 20: width of the shared delay counter; must hold max(QUIET, DETACH, SETTLE).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- boot_req, input, 1: boot request level from the bootloader.
- bridge_spi_cs, input, 1: SPI bridge chip select (active low).
- bridge_spi_sck, input, 1: SPI bridge clock.
- bridge_spi_mosi, input, 1: SPI bridge data.
- usb_tx_en_in, input, 1: protocol-engine transmit enable.
- spi_cs, output, 1: flash chip select.
- spi_sck, output, 1: flash clock.
- spi_mosi, output, 1: flash data.
- usb_detach, output, 1: forces pull-up off / pads SE0.
- warmboot, output, 1: warm-boot primitive trigger.
- image_sel, output, 2: warm-boot image select.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- States: IDLE, WAIT_QUIET, DETACH, FLASH_WAKE, SETTLE, BOOT. One shared down/up counter of width CNT_W.
- Reset (reset=0, async):
  - state=IDLE; counter=0; usb_detach=0; warmboot=0; image_sel=0; busy=0.
  - SPI outputs forced to cs=1, sck=0, mosi=0 while reset is low.
- IDLE and WAIT_QUIET:
  - spi_* = bridge_spi_* combinationally, with zero latency.
- Transitions:
  - IDLE -> WAIT_QUIET when boot_req=1, sampled on a clk edge.
  - After IDLE is left, the request is sticky: boot_req deassertion is ignored until reset.
- WAIT_QUIET:
  - The counter increments each cycle with bridge_spi_cs=1 and usb_tx_en_in=0.
  - Any cycle failing that condition clears the counter to 0.
  - At counter==QUIET_CYCLES-1 with the condition still true -> DETACH, counter cleared.
  - From the cycle DETACH is entered, spi_* are registered internal values: cs=1, sck=0, mosi=0.
- DETACH:
  - usb_detach=1 for exactly DETACH_CYCLES cycles, then -> FLASH_WAKE.
  - usb_detach stays 1 through all later states.
- FLASH_WAKE:
  - cs=0 for 16 cycles; WAKE_CMD shifted MSB first.
  - Each bit occupies 2 cycles: sck=0 with mosi=bit, then sck=1.
  - After bit 0's high phase: cs=1, sck=0 -> SETTLE.
  - Edge count is exactly 8 rising sck.
- SETTLE:
  - cs=1 for SETTLE_CYCLES cycles -> BOOT.
- BOOT:
  - warmboot=1 and image_sel=BOOT_IMAGE, held until reset.
  - Terminal state: no further SPI activity.
- Simultaneous events: if boot_req rises in the same cycle as bridge activity, enter WAIT_QUIET; the counter stays 0 that cycle.
- Reset mid-operation: any state returns immediately to IDLE with all outputs at their reset values, including mid-byte in FLASH_WAKE (cs rises asynchronously).
- Counter never wraps: each state compares against its limit and clears on exit.

Decomposition:
- Package warmboot_pkg:
  - state encoding (3-bit);
  - WAKE_CMD default;
  - flash timing constants (tRES1 cycles at 48 MHz).
- Sub-module spi_byte_tx:
  - inputs: start, 8-bit data;
  - outputs: cs, sck, mosi, done;
  - 16-cycle MSB-first shifter used by FLASH_WAKE.

Test Plan:
- Pass-through: in IDLE, toggle bridge_spi_* randomly for 200 cycles -> spi_* match the bridge inputs every cycle; busy=0.
- Quiet wait: boot_req=1 while bridge_spi_cs is pulsed low every 30 cycles (QUIET_CYCLES=48) -> remains in WAIT_QUIET with usb_detach=0. After activity stops -> usb_detach rises exactly 48 cycles after the last idle-breaking cycle.
- Full sequence (DETACH_CYCLES=100, SETTLE_CYCLES=10) -> observe, in order:
  - usb_detach high 100 cycles;
  - cs low 16 cycles;
  - mosi bits 1,0,1,0,1,0,1,1 on 8 sck rising edges;
  - cs high 10 cycles;
  - warmboot=1 and image_sel=2'b01, held 1000 cycles.
- Sticky request: pulse boot_req for 1 cycle only -> the full sequence still completes; warmboot=1.
- Reset mid-byte: assert reset=0 after the 5th sck rise -> cs=1, sck=0, warmboot=0, usb_detach=0 immediately. After release -> IDLE with pass-through restored.
- USB busy: hold usb_tx_en_in=1 with boot_req=1 -> state stays in WAIT_QUIET indefinitely. Release -> DETACH after 48 cycles.
